// File: rtl/priority_encoder.sv
// priority_encoder: latches request lines into a pending register and serialises
// them as a binary index stream on a valid/ready handshake. Each accepted index
// clears its pending bit.
// Optional feature macro ROUND_ROBIN_EN: rotating priority starting after the
// last served index. When it is undefined, the lowest pending index wins.
module priority_encoder #(
  parameter int unsigned OUTPUT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [(2**OUTPUT_WIDTH)-1:0]   req,
  input  logic                           en,
  output logic [OUTPUT_WIDTH-1:0]        q,
  output logic                           valid,
  input  logic                           ready,
  output logic                           busy
);

  localparam int unsigned W = OUTPUT_WIDTH;
  localparam int unsigned N = 2**OUTPUT_WIDTH;

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t         state;
  logic [N-1:0]   pend;
  logic [N-1:0]   set_v;
  logic [N-1:0]   clr_v;
  logic [N-1:0]   pend_nxt;
  logic           hs;
  logic           any_nxt;
  logic [W-1:0]   pick_q;
  logic           found;

  assign valid = (state == S_OFFER);

  // Next pending vector: accepted index cleared, new requests set (set wins).
  always_comb begin
    hs       = valid && ready;
    clr_v    = '0;
    if (hs) clr_v[q] = 1'b1;
    set_v    = en ? req : '0;
    pend_nxt = (pend & ~clr_v) | set_v;
    any_nxt  = |pend_nxt;
  end

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  logic [W-1:0] base;
  logic [W-1:0] idx;

  // The index just accepted becomes the new base, so it ranks last.
  assign base = hs ? q : ptr;

  // Rotating search over pend_nxt starting at base+1 and wrapping.
  always_comb begin
    pick_q = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = base + W'(k) + W'(1);
      if (!found && pend_nxt[idx]) begin
        pick_q = idx;
        found  = 1'b1;
      end
    end
  end

  // Round-robin pointer follows each accepted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= W'(N - 1);
    end else if (hs) begin
      ptr <= q;
    end
  end
`else
  // Fixed priority search over pend_nxt: lowest index wins.
  always_comb begin
    pick_q = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && pend_nxt[k]) begin
        pick_q = W'(k);
        found  = 1'b1;
      end
    end
  end
`endif

  // Pending register, busy flag and the IDLE/OFFER output state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= '0;
      busy  <= 1'b0;
      q     <= '0;
      state <= S_IDLE;
    end else begin
      pend <= pend_nxt;
      busy <= any_nxt;
      case (state)
        S_IDLE: begin
          if (any_nxt) begin
            state <= S_OFFER;
            q     <= pick_q;
          end
        end
        S_OFFER: begin
          if (hs) begin
            if (any_nxt) begin
              q <= pick_q;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder (OUTPUT_WIDTH = 4). A behavioural
// model tracks pending requests as a bit array and the offered index as an int;
// every negative edge the DUT outputs are compared against it. Directed
// scenarios add literal expectations; a randomized phase follows.
// Build with ROUND_ROBIN_EN defined to check the rotating-priority variant.
module tb_priority_encoder;

  localparam int OW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic          en = 1'b0;
  logic          ready = 1'b0;
  logic [OW-1:0] q;
  logic          valid;
  logic          busy;

  int checks = 0;
  int errors = 0;

  priority_encoder #(.OUTPUT_WIDTH(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (en),
    .q     (q),
    .valid (valid),
    .ready (ready),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pend [N];
  bit m_valid = 1'b0;
  int m_q = 0;
  int m_ptr = N - 1;
  bit m_hs;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic int m_choose();
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++)
      if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (m_pend[i]) return i;
`endif
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_q     = 0;
      m_ptr   = N - 1;
    end else begin
      m_hs = m_valid && ready;
      if (m_hs) begin
        m_pend[m_q] = 1'b0;
        m_ptr       = m_q;
      end
      for (int i = 0; i < N; i++)
        if (en && req[i]) m_pend[i] = 1'b1;
      if (!m_valid || m_hs) begin
        if (m_count() > 0) begin
          m_valid = 1'b1;
          m_q     = m_choose();
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Continuous comparison against the model.
  always @(negedge clk) begin
    chk("model_valid", 32'(valid), 32'(m_valid));
    chk("model_busy",  32'(busy),  32'(m_count() > 0));
    chk("model_q",     32'(q),     32'(m_q));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic e, input logic rd);
    req   = r;
    en    = e;
    ready = rd;
  endtask

  task automatic lit(input string name, input logic v, input int qq, input logic b);
    chk({name, "_valid"}, 32'(valid), 32'(v));
    chk({name, "_busy"},  32'(busy),  32'(b));
    if (v) chk({name, "_q"}, 32'(q), 32'(qq));
  endtask

  task automatic drain();
    drive('0, 1'b0, 1'b1);
    repeat (N + 2) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with every request asserted.
    drive('1, 1'b1, 1'b0);
    tick(); tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_q",     32'(q),     32'd0);
    rst_n = 1'b1;
    tick();
    lit("rel", 1'b1, 0, 1'b1);

    // Full register drains in N handshakes.
    drive('0, 1'b0, 1'b1);
    repeat (N) tick();
    chk("full_empty_valid", 32'(valid), 32'd0);
    chk("full_empty_busy",  32'(busy),  32'd0);
    chk("full_last_q",      32'(q),     32'd15);

    // Single request.
    drive(16'h0100, 1'b1, 1'b1); tick();
    lit("single", 1'b1, 8, 1'b1);
    drive('0, 1'b1, 1'b1); tick();
    lit("single_done", 1'b0, 0, 1'b0);

    // Backpressure.
    drive(16'h0022, 1'b1, 1'b0); tick();
    lit("bp_first", 1'b1, 1, 1'b1);
    drive('0, 1'b1, 1'b0);
    repeat (5) begin
      tick();
      lit("bp_stall", 1'b1, 1, 1'b1);
    end
    drive('0, 1'b1, 1'b1); tick();
    lit("bp_second", 1'b1, 5, 1'b1);
    tick();
    lit("bp_idle", 1'b0, 0, 1'b0);

    // Higher-priority arrival during a stall does not disturb q.
    drive(16'h0004, 1'b1, 1'b0); tick();
    lit("hp_offer", 1'b1, 2, 1'b1);
    drive(16'h0001, 1'b1, 1'b0); tick();
    lit("hp_hold", 1'b1, 2, 1'b1);
    drive('0, 1'b1, 1'b0); tick();
    lit("hp_hold2", 1'b1, 2, 1'b1);
    drive('0, 1'b1, 1'b1); tick();
    lit("hp_next", 1'b1, 0, 1'b1);
    tick();
    lit("hp_idle", 1'b0, 0, 1'b0);

    // Single pulse of two requests.
    drive(16'h8001, 1'b1, 1'b1); tick();
`ifdef ROUND_ROBIN_EN
    lit("pulse_a", 1'b1, 15, 1'b1);
    drive('0, 1'b1, 1'b1); tick();
    lit("pulse_b", 1'b1, 0, 1'b1);
`else
    lit("pulse_a", 1'b1, 0, 1'b1);
    drive('0, 1'b1, 1'b1); tick();
    lit("pulse_b", 1'b1, 15, 1'b1);
`endif
    tick();
    lit("pulse_idle", 1'b0, 0, 1'b0);

`ifdef ROUND_ROBIN_EN
    // Held requests rotate.
    do_reset();
    drive(16'h0007, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      lit("rr_seq", 1'b1, i % 3, 1'b1);
    end
`else
    // Held requests: index 0 re-latched on every edge and always wins.
    drive(16'h8001, 1'b1, 1'b1);
    repeat (4) begin
      tick();
      lit("fixed_held", 1'b1, 0, 1'b1);
    end
    drive('0, 1'b1, 1'b1); tick();
    lit("fixed_release", 1'b1, 15, 1'b1);
`endif
    drain();

    // Set wins over clear on the handshake edge.
    drive(16'h0008, 1'b1, 1'b0); tick();
    lit("coll_offer", 1'b1, 3, 1'b1);
    drive(16'h0008, 1'b1, 1'b1); tick();
    lit("coll_again", 1'b1, 3, 1'b1);
    drive('0, 1'b1, 1'b1); tick();
    lit("coll_done", 1'b0, 0, 1'b0);

    // Capture disabled.
    drive('1, 1'b0, 1'b1);
    repeat (4) begin
      tick();
      lit("en_low", 1'b0, 0, 1'b0);
    end

    // Randomized phase with occasional asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      r = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      drive(r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_busy",  32'(busy),  32'd0);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    drain();
    chk("final_idle", 32'(valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
